// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the IMem program loader.
package imem_loader_pkg;

  localparam int DEFAULT_ADDR_W = 7;
  localparam int HDR_BYTES      = 2;
  localparam int CSUM_BYTES     = 1;
  localparam int WORD_BYTES     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted payload bytes into little-endian words and keeps the running XOR.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_ready,
  output logic [31:0] word_data,
  output logic [7:0]  csum_acc
);

  logic [1:0]  byte_cnt;
  logic [31:0] shift_q;

  // Bytes enter at the top so the first byte of a word ends up in [7:0].
  assign word_data  = {byte_data, shift_q[31:8]};
  assign word_ready = byte_en && (byte_cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      shift_q  <= '0;
      csum_acc <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      shift_q  <= '0;
      csum_acc <= '0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift_q  <= word_data;
      csum_acc <= csum_acc ^ byte_data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for IMem; releases the CPU only after a verified load.
//   state   | meaning
//   IDLE    | waiting for start after reset
//   HDR0    | expecting word-count low byte
//   HDR1    | expecting word-count high byte, range check
//   DATA    | payload bytes, one write per 4 bytes
//   CSUM    | expecting XOR checksum byte
//   DONE    | load verified, CPU released
//   ERR     | bad header or checksum, CPU held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_rst_n
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t            state, state_nxt;
  logic [7:0]        n_lo;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   word_cnt_inc;
  logic [15:0]       hdr_n;
  logic              hdr_ok;
  logic              xfer;
  logic              data_en;
  logic              start_take;
  logic              word_ready;
  logic [31:0]       word_data;
  logic [7:0]        csum_acc;

  assign byte_ready = (state == ST_HDR0) || (state == ST_HDR1) ||
                      (state == ST_DATA) || (state == ST_CSUM);
  assign busy       = byte_ready;
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_ERR);
  assign cpu_rst_n  = (state == ST_DONE);

  assign xfer       = byte_valid && byte_ready;
  assign data_en    = xfer && (state == ST_DATA);
  assign start_take = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                                (state == ST_ERR));

  // Count is unsigned 16-bit; anything beyond DEPTH would wrap the address.
  assign hdr_n        = {byte_data, n_lo};
  assign hdr_ok       = (hdr_n != 16'd0) && ({1'b0, hdr_n} <= DEPTH_W);
  assign word_cnt_inc = word_cnt + (ADDR_W + 1)'(1);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_take),
    .byte_en    (data_en),
    .byte_data  (byte_data),
    .word_ready (word_ready),
    .word_data  (word_data),
    .csum_acc   (csum_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_nxt = ST_HDR0;
      ST_HDR0: if (xfer) state_nxt = ST_HDR1;
      ST_HDR1: if (xfer) state_nxt = hdr_ok ? ST_DATA : ST_ERR;
      ST_DATA: if (word_ready && (word_cnt_inc == n_words)) state_nxt = ST_CSUM;
      ST_CSUM: if (xfer) state_nxt = (byte_data == csum_acc) ? ST_DONE : ST_ERR;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The write port registers make the word visible the cycle after its 4th byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lo     <= '0;
      n_words  <= '0;
      word_cnt <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      we <= word_ready;
      if (start_take) begin
        n_lo     <= '0;
        n_words  <= '0;
        word_cnt <= '0;
      end
      if ((state == ST_HDR0) && xfer) n_lo <= byte_data;
      if ((state == ST_HDR1) && xfer && hdr_ok) n_words <= hdr_n[ADDR_W:0];
      if (word_ready) begin
        waddr    <= word_cnt[ADDR_W-1:0];
        wdata    <= word_data;
        word_cnt <= word_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames built from a word-list model, writes checked by a monitor.
module tb_imem_loader;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_rst_n;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_rst_n  (cpu_rst_n)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0]        word_q[$];
  logic [7:0]         frame_q[$];
  bit                 exp_done;
  logic [ADDR_W+31:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every write pulse must match the next expected write.
  always @(negedge clk) begin
    if (rst_n && we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_we: got write addr %0d data %0h, expected none", waddr, wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("we_addr", 64'(waddr), 64'(mon_e[ADDR_W+31:32]));
        check("we_data", 64'(wdata), 64'(mon_e[31:0]));
      end
    end
  end

  // Reference model: frame bytes, expected writes and outcome from word_q.
  task automatic build_frame(input int n, input bit bad_csum);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [15:0] n16;
    n16 = 16'(n);
    frame_q = {};
    frame_q.push_back(n16[7:0]);
    frame_q.push_back(n16[15:8]);
    if (n == 0 || n > DEPTH) begin
      exp_done = 1'b0;
      return;
    end
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = word_q[i];
      for (int b = 0; b < 4; b++) begin
        frame_q.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
      exp_q.push_back({ADDR_W'(i), w});
    end
    frame_q.push_back(bad_csum ? (cs ^ 8'h01) : cs);
    exp_done = !bad_csum;
  endtask

  task automatic random_words(input int n);
    word_q = {};
    for (int i = 0; i < n; i++) word_q.push_back($urandom);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ready_after_start", 64'(byte_ready), 64'd1);
    check("busy_after_start", 64'(busy), 64'd1);
    check("flags_cleared", 64'({done, error, cpu_rst_n}), 64'd0);
  endtask

  task automatic send(input int lo, input int hi, input int gap);
    int idx;
    int guard;
    bit took;
    idx = lo;
    guard = 0;
    while (idx < hi) begin
      if (int'($urandom_range(99)) < gap) byte_valid = 1'b0;
      else begin
        byte_valid = 1'b1;
        byte_data  = frame_q[idx];
      end
      @(negedge clk);
      took = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (took) idx++;
      guard++;
      if (guard > 20000) begin
        check("send_timeout", 64'(idx), 64'(hi));
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic finish_check(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_error"}, 64'(error), 64'(!exp_done));
    check({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(exp_done));
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_writes_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 64'({byte_ready, we, busy, done, error, cpu_rst_n}), 64'd0);
    check({tag, "_waddr"}, 64'(waddr), 64'd0);
    check({tag, "_wdata"}, 64'(wdata), 64'd0);
  endtask

  task automatic directed_words();
    word_q = {};
    word_q.push_back(32'h12345678);
    word_q.push_back(32'hDEADBEEF);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed good load
    directed_words();
    do_start();
    build_frame(2, 1'b0);
    check("dir_csum_byte", 64'(frame_q[10]), 64'h2A);
    send(0, frame_q.size(), 0);
    finish_check("good");

    // Bad checksum, then clean restart
    do_start();
    build_frame(2, 1'b1);
    send(0, frame_q.size(), 20);
    finish_check("badcsum");
    do_start();
    build_frame(2, 1'b0);
    send(0, frame_q.size(), 20);
    finish_check("restart");

    // Header range errors
    do_start();
    build_frame(0, 1'b0);
    send(0, 2, 10);
    finish_check("hdr_zero");
    do_start();
    build_frame(DEPTH + 1, 1'b0);
    send(0, 2, 10);
    finish_check("hdr_129");
    do_start();
    build_frame(16'h0100, 1'b0);
    send(0, 2, 10);
    finish_check("hdr_256");

    // Random short loads
    for (int it = 0; it < 8; it++) begin
      int n;
      bit bad;
      n   = int'($urandom_range(10, 1));
      bad = ($urandom_range(3) == 0);
      random_words(n);
      do_start();
      build_frame(n, bad);
      send(0, frame_q.size(), 40);
      finish_check("rand");
    end

    // Full-depth load with gaps
    random_words(DEPTH);
    do_start();
    build_frame(DEPTH, 1'b0);
    send(0, frame_q.size(), 30);
    check("full_last_waddr", 64'(waddr), 64'(DEPTH - 1));
    finish_check("full");

    // Start during DATA is ignored
    random_words(4);
    do_start();
    build_frame(4, 1'b0);
    send(0, 8, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_ignored_busy", 64'(busy), 64'd1);
    send(8, frame_q.size(), 20);
    finish_check("start_in_data");

    // Reset during word 5 of a full load
    random_words(DEPTH);
    do_start();
    build_frame(DEPTH, 1'b0);
    send(0, 2 + 4 * 5 + 2, 25);
    @(posedge clk); #1;
    check("midreset_writes_before", 64'(exp_q.size()), 64'(DEPTH - 5));
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset_now");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("midreset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    check("midreset_idle", 64'({busy, byte_ready, cpu_rst_n}), 64'd0);

    // Recovery after reset
    directed_words();
    do_start();
    build_frame(2, 1'b0);
    send(0, frame_q.size(), 10);
    finish_check("recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
